// File: rtl/cmplx_mult_pkg.sv
// Shared types and constants for the sequential complex multiplier.
package cmplx_mult_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 2 * DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_RR,
        MUL_II,
        MUL_RI,
        MUL_IR,
        DRAIN,
        DONE
    } cm_state_t;

    typedef logic signed [OUT_W-1:0] cm_acc_t;

    function automatic cm_acc_t sext_prod(input logic signed [2*DATA_W-1:0] p);
        return cm_acc_t'(p);
    endfunction

endpackage

// File: rtl/mult.sv
// Existing 8x8 signed multiplier, purely combinational.
module mult (
    input  logic signed [7:0]  a_i,
    input  logic signed [7:0]  b_i,
    output logic signed [15:0] p_o
);

    assign p_o = 16'(a_i) * 16'(b_i);

endmodule

// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier: one shared signed multiplier computes the four partial
// products in turn, accumulated into 17-bit real/imaginary results behind valid/ready.
module cmplx_mult_seq
    import cmplx_mult_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned REG_PROD = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ar,
    input  logic signed [DATA_W-1:0] ai,
    input  logic signed [DATA_W-1:0] br,
    input  logic signed [DATA_W-1:0] bi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [2*DATA_W:0] yr,
    output logic signed [2*DATA_W:0] yi,
    output logic                     busy
);

    if (DATA_W != 8) begin : g_bad_width
        $error("cmplx_mult_seq: DATA_W must be 8 to match mult");
    end

    cm_state_t                  state_q;
    logic signed [DATA_W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic signed [DATA_W-1:0]   mul_a, mul_b;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] term_p;
    cm_state_t                  term_st;
    cm_acc_t                    p_ext;
    cm_acc_t                    acc_r_q, acc_i_q, acc_r_d, acc_i_d;
    cm_acc_t                    yr_q, yi_q;
    logic                       in_ready_q, busy_q, out_valid_q;

    // Operand select for the shared multiplier, driven only from the latched copies.
    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (state_q)
            MUL_II: begin
                mul_a = ai_q;
                mul_b = bi_q;
            end
            MUL_RI: begin
                mul_a = ar_q;
                mul_b = bi_q;
            end
            MUL_IR: begin
                mul_a = ai_q;
                mul_b = br_q;
            end
            default: ;
        endcase
    end

    mult u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // term_st names the partial product that is folded into the accumulators this cycle.
    if (REG_PROD != 0) begin : g_prod_reg
        logic signed [2*DATA_W-1:0] prod_q;
        cm_state_t                  term_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q <= '0;
                term_q <= IDLE;
            end else begin
                prod_q <= prod;
                term_q <= state_q;
            end
        end

        assign term_p  = prod_q;
        assign term_st = term_q;
    end else begin : g_prod_comb
        assign term_p  = prod;
        assign term_st = state_q;
    end

    always_comb begin
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        p_ext   = sext_prod(term_p);
        case (term_st)
            MUL_RR:  acc_r_d = p_ext;
            MUL_II:  acc_r_d = acc_r_q - p_ext;
            MUL_RI:  acc_i_d = p_ext;
            MUL_IR:  acc_i_d = acc_i_q + p_ext;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            yr_q        <= '0;
            yi_q        <= '0;
        end else begin
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ar_q       <= ar;
                        ai_q       <= ai;
                        br_q       <= br;
                        bi_q       <= bi;
                        state_q    <= MUL_RR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL_RR: state_q <= MUL_II;
                MUL_II: state_q <= MUL_RI;
                MUL_RI: state_q <= MUL_IR;
                MUL_IR: begin
                    if (REG_PROD != 0) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        yr_q        <= acc_r_d;
                        yi_q        <= acc_i_d;
                    end
                end
                DRAIN: begin
                    if (REG_PROD != 0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        yr_q        <= acc_r_d;
                        yi_q        <= acc_i_d;
                    end else begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign yr        = yr_q;
    assign yi        = yi_q;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Scoreboard bench for cmplx_mult_seq: one instance per REG_PROD value, directed corner
// cases followed by randomized traffic with input and output stalls.
module tb_cmplx_mult_seq;

    typedef struct {
        int r;
        int i;
    } exp_t;

    localparam int NRAND = 2500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid [2];
    logic              in_ready [2];
    logic signed [7:0] ar [2];
    logic signed [7:0] ai [2];
    logic signed [7:0] br [2];
    logic signed [7:0] bi [2];
    logic              out_valid [2];
    logic              out_ready [2];
    logic signed [16:0] yr [2];
    logic signed [16:0] yi [2];
    logic              busy [2];

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    bit   hold_q [2];
    int   hold_r [2];
    int   hold_i [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmplx_mult_seq #(.DATA_W(8), .REG_PROD(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .ar        (ar[0]),
        .ai        (ai[0]),
        .br        (br[0]),
        .bi        (bi[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .yr        (yr[0]),
        .yi        (yi[0]),
        .busy      (busy[0])
    );

    cmplx_mult_seq #(.DATA_W(8), .REG_PROD(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .ar        (ar[1]),
        .ai        (ai[1]),
        .br        (br[1]),
        .bi        (bi[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .yr        (yr[1]),
        .yi        (yi[1]),
        .busy      (busy[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rs8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Presents one operand set, waits for acceptance and records the expected product.
    task automatic issue(input int k, input int a_r, input int a_i, input int b_r,
                         input int b_i, input bit hold, output int acc);
        int   n;
        exp_t e;
        n = 0;
        ar[k] = 8'(a_r);
        ai[k] = 8'(a_i);
        br[k] = 8'(b_r);
        bi[k] = 8'(b_i);
        in_valid[k] = 1'b1;
        @(negedge clk);
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept%0d", k), int'(in_ready[k]), 1);
        acc = cyc;
        e.r = a_r * b_r - a_i * b_i;
        e.i = a_r * b_i + a_i * b_r;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge clk);
        #1;
        ar[k] = 8'($urandom);
        ai[k] = 8'($urandom);
        br[k] = 8'($urandom);
        bi[k] = 8'($urandom);
        in_valid[k] = hold;
    endtask

    task automatic wait_valid(input int k, input int acc, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[k] && n < 40);
        check($sformatf("latency%0d", k), cyc - acc, lat);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int k, input int n);
        int acc;
        int g;
        for (int j = 0; j < n; j++) begin
            g = $urandom_range(0, 2);
            if (g != 0) in_valid[k] = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            issue(k, rs8(), rs8(), rs8(), rs8(), 1'($urandom_range(0, 1)), acc);
        end
        in_valid[k] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every result handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (hold_q[k]) begin
                check($sformatf("hold_valid%0d", k), int'(out_valid[k]), 1);
                check($sformatf("hold_yr%0d", k), int'(yr[k]), hold_r[k]);
                check($sformatf("hold_yi%0d", k), int'(yi[k]), hold_i[k]);
            end
            if (out_valid[k] && out_ready[k]) begin
                if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                    check($sformatf("spurious%0d", k), int'(out_valid[k]), 0);
                end else begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("yr%0d", k), int'(yr[k]), e.r);
                    check($sformatf("yi%0d", k), int'(yi[k]), e.i);
                end
            end
            hold_q[k] = out_valid[k] && !out_ready[k];
            hold_r[k] = int'(yr[k]);
            hold_i[k] = int'(yi[k]);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs[4];
        bit d0;
        bit d1;
        d0 = 1'b0;
        d1 = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            ar[k] = '0;
            ai[k] = '0;
            br[k] = '0;
            bi[k] = '0;
        end
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready%0d", k), int'(in_ready[k]), 1);
            check($sformatf("rst_out_valid%0d", k), int'(out_valid[k]), 0);
            check($sformatf("rst_busy%0d", k), int'(busy[k]), 0);
            check($sformatf("rst_yr%0d", k), int'(yr[k]), 0);
            check($sformatf("rst_yi%0d", k), int'(yi[k]), 0);
        end

        // Basic product and latency on both variants
        issue(0, 3, 4, 5, -2, 1'b0, acc);
        wait_valid(0, acc, 5);
        @(negedge clk);
        check("pulse_width0", int'(out_valid[0]), 0);
        wait_idle();
        issue(1, 3, 4, 5, -2, 1'b0, acc);
        wait_valid(1, acc, 6);
        wait_idle();

        // Full 17-bit range corners
        issue(0, -128, -128, -128, -128, 1'b0, acc);
        wait_valid(0, acc, 5);
        wait_idle();
        issue(0, -128, 127, -128, -128, 1'b0, acc);
        wait_valid(0, acc, 5);
        wait_idle();

        // Backpressure: result held stable for 10 cycles
        out_ready[0] = 1'b0;
        issue(0, 1, 1, 1, 1, 1'b0, acc);
        wait_valid(0, acc, 5);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid[0]), 1);
            check("bp_yr", int'(yr[0]), 0);
            check("bp_yi", int'(yi[0]), 2);
            check("bp_in_ready", int'(in_ready[0]), 0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", int'(out_valid[0]), 0);
        check("bp_release_in_ready", int'(in_ready[0]), 1);
        wait_idle();

        // Back-to-back with in_valid held high, REG_PROD=1
        for (int j = 0; j < 4; j++) issue(1, rs8(), rs8(), rs8(), rs8(), 1'b1, accs[j]);
        in_valid[1] = 1'b0;
        for (int j = 1; j < 4; j++) check("b2b_spacing", accs[j] - accs[j-1], 7);
        wait_idle();

        // Reset during MUL_II abandons the transaction
        issue(0, 5, 6, 7, 8, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb0.delete();
        check("mid_rst_valid", int'(out_valid[0]), 0);
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_yr", int'(yr[0]), 0);
        check("mid_rst_yi", int'(yi[0]), 0);
        check("mid_rst_in_ready", int'(in_ready[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 2, -3, -4, 1, 1'b0, acc);
        wait_valid(0, acc, 5);
        wait_idle();

        // Random traffic with stalls on both variants
        fork
            begin
                rand_run(0, NRAND);
                d0 = 1'b1;
            end
            begin
                rand_run(1, NRAND);
                d1 = 1'b1;
            end
            begin
                while (!(d0 && d1)) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                    out_ready[1] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        wait_idle();
        check("lost0", sb0.size(), 0);
        check("lost1", sb1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
